// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/sdata on clk and emits one signed
// left/right pair per frame, with a pulse for slots of the wrong length.
module i2s_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int SLOT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i2s_bclk,
    input  logic                  i2s_lrclk,
    input  logic                  i2s_sdata,
    output logic [DATA_WIDTH-1:0] left_data,
    output logic [DATA_WIDTH-1:0] right_data,
    output logic                  sample_valid,
    output logic                  frame_err
);

    localparam logic [6:0] DW_C       = 7'(DATA_WIDTH);
    localparam logic [5:0] LAST_IDX_C = 6'(SLOT_WIDTH - 1);
    localparam logic [5:0] SAT_IDX_C  = 6'd63;

    typedef enum logic [0:0] {
        ST_UNALIGNED = 1'b0,
        ST_RUN       = 1'b1
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic                  bclk_meta_r;
    logic                  bclk_sync_r;
    logic                  bclk_dly_r;
    logic                  lr_meta_r;
    logic                  lr_sync_r;
    logic                  sd_meta_r;
    logic                  sd_sync_r;
    logic                  lr_prev_r;
    logic [5:0]            bit_idx_r;
    logic [DATA_WIDTH-1:0] shift_r;
    logic [DATA_WIDTH-1:0] stage_r;
    logic                  left_ok_r;
    logic                  rise_s;
    logic                  change_s;
    logic                  capture_s;
    logic [DATA_WIDTH:0]   shift_in_s;
    logic [DATA_WIDTH-1:0] word_s;
    logic                  align_s;
    logic                  complete_s;
    logic                  err_s;
    logic                  load_left_s;
    logic                  load_pair_s;

    // Pin synchronisers run through rst so that reset release cannot fake an edge.
    always_ff @(posedge clk) begin
        bclk_meta_r <= i2s_bclk;
        bclk_sync_r <= bclk_meta_r;
        bclk_dly_r  <= bclk_sync_r;
        lr_meta_r   <= i2s_lrclk;
        lr_sync_r   <= lr_meta_r;
        sd_meta_r   <= i2s_sdata;
        sd_sync_r   <= sd_meta_r;
    end

    // Event decode and the word as it would look with the current bit shifted in.
    always_comb begin
        rise_s     = bclk_sync_r & ~bclk_dly_r;
        change_s   = rise_s & (lr_sync_r != lr_prev_r);
        capture_s  = ({1'b0, bit_idx_r} < DW_C);
        shift_in_s = {shift_r, sd_sync_r};
        if (capture_s) begin
            word_s = shift_in_s[DATA_WIDTH-1:0];
        end else begin
            word_s = shift_r;
        end
    end

    // Alignment FSM: next state and per-change-edge decisions.
    always_comb begin
        state_nxt_s = state_r;
        align_s     = 1'b0;
        complete_s  = 1'b0;
        err_s       = 1'b0;
        case (state_r)
            ST_UNALIGNED: begin
                if (change_s) begin
                    state_nxt_s = ST_RUN;
                    align_s     = 1'b1;
                end else begin
                    state_nxt_s = ST_UNALIGNED;
                end
            end
            ST_RUN: begin
                if (change_s && (bit_idx_r == LAST_IDX_C)) begin
                    complete_s = 1'b1;
                end else if (change_s) begin
                    err_s = 1'b1;
                end else begin
                    complete_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_UNALIGNED;
            end
        endcase
        // lr_prev_r still names the outgoing slot's channel on the change edge.
        load_left_s = complete_s & ~lr_prev_r;
        load_pair_s = complete_s & lr_prev_r & left_ok_r;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_UNALIGNED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Previous-rise lrclk; follows the pin during rst so release is edge-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            lr_prev_r <= lr_sync_r;
        end else if (rise_s) begin
            lr_prev_r <= lr_sync_r;
        end
    end

    // Bit counter, shift register, left staging and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_idx_r    <= 6'd0;
            shift_r      <= '0;
            stage_r      <= '0;
            left_ok_r    <= 1'b0;
            left_data    <= '0;
            right_data   <= '0;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            sample_valid <= load_pair_s;
            frame_err    <= err_s;
            if (change_s) begin
                bit_idx_r <= 6'd0;
                shift_r   <= '0;
            end else if (rise_s && (state_r == ST_RUN)) begin
                if (bit_idx_r != SAT_IDX_C) begin
                    bit_idx_r <= bit_idx_r + 6'd1;
                end
                if (capture_s) begin
                    shift_r <= word_s;
                end
            end
            if (align_s || err_s || load_pair_s) begin
                left_ok_r <= 1'b0;
            end else if (load_left_s) begin
                left_ok_r <= 1'b1;
            end
            if (load_left_s) begin
                stage_r <= word_s;
            end
            if (load_pair_s) begin
                left_data  <= stage_r;
                right_data <= word_s;
            end
        end
    end

endmodule
